// File: rtl/load_queue_pkg.sv
// load_queue_pkg
//   Shared types and configuration for the load queue.
//   - cpu_config_t carries the queue depths that size the load queue and
//     the store-conflict masks.
//   - id_t / lq_entry_t describe one queued load at the default widths.
//   - is_pow2() is used to reject illegal depth parameters at elaboration.
package load_queue_pkg;

  localparam int LOG2_MAX_IDS   = 3;
  localparam int SUBUNIT_ID_W   = 2;

  typedef logic [LOG2_MAX_IDS-1:0] id_t;

  typedef struct packed {
    int unsigned lq_depth;
    int unsigned sq_depth;
  } cpu_config_t;

  localparam cpu_config_t DEFAULT_CONFIG = '{lq_depth: 4, sq_depth: 4};

  typedef struct packed {
    logic [31:0]             addr;
    logic [2:0]              fn3;
    id_t                     id;
    logic [SUBUNIT_ID_W-1:0] subunit_id;
  } lq_entry_t;

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/load_queue.sv
// load_queue
//   In-order FIFO of issued loads feeding the memory request path. Each
//   entry captures the store queue's potential_store_conflicts mask at push
//   time; the oldest entry's mask is returned as prev_store_conflicts so the
//   store queue can report whether any of those stores is still unissued
//   (store_conflict). The oldest load is only offered while no such store
//   remains.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   push, data_in_*            enqueue one load (addr, fn3, id, subunit)
//   potential_store_conflicts  store mask captured with the pushed load
//   lq_push / lq_pop           echoes of push / pop for the store queue
//   full                       registered; push only legal if ~full | pop
//   empty                      no valid entries
//   valid                      oldest load may be issued
//   pop                        consumer takes the oldest load
//   data_out_*                 oldest entry payload (combinational read)
//   prev_store_conflicts       oldest entry's captured mask, 0 when none
//   store_conflict             from store queue: an older store is pending
//
// Handshake: the producer may assert push in any cycle where full=0 or pop=1;
// the entry is visible at the output from the following cycle (no bypass).
// The consumer may assert pop only in a cycle where valid=1; the oldest entry
// is retired at that clock edge. push and pop in the same cycle both take
// effect and leave occupancy unchanged.
module load_queue
  import load_queue_pkg::*;
#(
  parameter int LQ_DEPTH  = int'(DEFAULT_CONFIG.lq_depth),
  parameter int SQ_DEPTH  = int'(DEFAULT_CONFIG.sq_depth),
  parameter int ID_W      = LOG2_MAX_IDS,
  parameter int SUBUNIT_W = SUBUNIT_ID_W
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 push,
  input  logic [31:0]          data_in_addr,
  input  logic [2:0]           data_in_fn3,
  input  logic [ID_W-1:0]      data_in_id,
  input  logic [SUBUNIT_W-1:0] data_in_subunit_id,
  input  logic [SQ_DEPTH-1:0]  potential_store_conflicts,
  output logic                 lq_push,

  output logic                 full,
  output logic                 empty,
  output logic                 valid,

  input  logic                 pop,
  output logic                 lq_pop,
  output logic [31:0]          data_out_addr,
  output logic [2:0]           data_out_fn3,
  output logic [ID_W-1:0]      data_out_id,
  output logic [SUBUNIT_W-1:0] data_out_subunit_id,
  output logic [SQ_DEPTH-1:0]  prev_store_conflicts,
  input  logic                 store_conflict
);

  localparam int PTR_W = $clog2(LQ_DEPTH);

  if (!is_pow2(LQ_DEPTH) || LQ_DEPTH < 2) begin : g_bad_depth
    $error("load_queue: LQ_DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [31:0]          addr;
    logic [2:0]           fn3;
    logic [ID_W-1:0]      id;
    logic [SUBUNIT_W-1:0] subunit_id;
  } entry_t;

  // Payload and mask storage: plain arrays, no reset, suited to LUTRAM.
  entry_t              entry_mem [LQ_DEPTH];
  logic [SQ_DEPTH-1:0] mask_mem  [LQ_DEPTH];

  logic [PTR_W-1:0]    lq_index_q,  lq_index_d;
  logic [PTR_W-1:0]    lq_oldest_q, lq_oldest_d;
  logic [LQ_DEPTH-1:0] valid_r_q,   valid_r_d;
  logic [LQ_DEPTH-1:0] push_onehot, pop_onehot;
  logic                full_q,      full_d;

  entry_t              oldest_entry;
  logic                oldest_valid;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    push_onehot = '0;
    pop_onehot  = '0;
    if (push) push_onehot[lq_index_q]  = 1'b1;
    if (pop)  pop_onehot[lq_oldest_q]  = 1'b1;

    lq_index_d  = push ? lq_index_q  + PTR_W'(1) : lq_index_q;
    lq_oldest_d = pop  ? lq_oldest_q + PTR_W'(1) : lq_oldest_q;

    // Clear before set: when the queue is full and push+pop hit the same
    // slot, the freshly written entry must survive.
    valid_r_d = (valid_r_q & ~pop_onehot) | push_onehot;

    // Full next cycle when the slot the write pointer will land on is still
    // occupied.
    full_d = valid_r_d[lq_index_d];
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lq_index_q  <= '0;
      lq_oldest_q <= '0;
      valid_r_q   <= '0;
      full_q      <= 1'b0;
    end else begin
      lq_index_q  <= lq_index_d;
      lq_oldest_q <= lq_oldest_d;
      valid_r_q   <= valid_r_d;
      full_q      <= full_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage: written on push, never modified afterwards
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      entry_mem[lq_index_q] <= '{addr:       data_in_addr,
                                 fn3:        data_in_fn3,
                                 id:         data_in_id,
                                 subunit_id: data_in_subunit_id};
      mask_mem[lq_index_q]  <= potential_store_conflicts;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    oldest_entry = entry_mem[lq_oldest_q];
    oldest_valid = valid_r_q[lq_oldest_q];
  end

  assign lq_push = push;
  assign lq_pop  = pop;

  assign full  = full_q;
  assign empty = ~|valid_r_q;

  // Combinational gate so a store issuing this cycle releases the load
  // without an added cycle.
  assign valid = oldest_valid & ~store_conflict;

  assign data_out_addr       = oldest_entry.addr;
  assign data_out_fn3        = oldest_entry.fn3;
  assign data_out_id         = oldest_entry.id;
  assign data_out_subunit_id = oldest_entry.subunit_id;

  // Masked so the unreset storage can never leak X to the store queue.
  assign prev_store_conflicts = oldest_valid ? mask_mem[lq_oldest_q] : '0;

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(push && full_q && !pop))
    else $error("load_queue: push while full without pop");

  a_no_pop_when_invalid : assert property (@(posedge clk) disable iff (rst)
    !(pop && !valid))
    else $error("load_queue: pop while valid is low");

endmodule
